// File: rtl/chime_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : chime_alarm_ctrl
//  Description : Speaker sequencer for the digital clock. Arbitrates between
//                the hourly chime (xx:59:51/53/55/57 low tone, xx:59:59 high
//                tone) and a daily alarm, and holds the adjustable alarm time.
//  Revision    : 1.0 - initial release
// ============================================================================
module chime_alarm_ctrl #(
    parameter int CYC_PER_SEC = 1024,
    parameter int HI_HALF     = 1,
    parameter int LO_HALF     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [5:0] hour,
    input  logic [6:0] minute,
    input  logic [6:0] second,
    input  logic       alm_en,
    input  logic       alm_set_en,
    input  logic       alm_hour_inc,
    input  logic       alm_min_inc,
    input  logic       alm_stop,
    output logic       speaker,
    output logic [5:0] alm_hour,
    output logic [6:0] alm_min,
    output logic       ringing,
    output logic       chiming
);

    // Sound window is half a second; counter only needs to reach CYC_PER_SEC/2-1
    localparam int c_WIN_W    = $clog2(CYC_PER_SEC);
    localparam int c_HALF_MAX = (HI_HALF > LO_HALF) ? HI_HALF : LO_HALF;
    localparam int c_HALF_W   = (c_HALF_MAX > 1) ? $clog2(c_HALF_MAX) : 1;

    localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(CYC_PER_SEC / 2 - 1);
    localparam logic [c_HALF_W-1:0] c_HI_LAST  = c_HALF_W'(HI_HALF - 1);
    localparam logic [c_HALF_W-1:0] c_LO_LAST  = c_HALF_W'(LO_HALF - 1);
    localparam logic [5:0]          c_RING_LAST = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHIME_LO = 2'd1,
        ST_CHIME_HI = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_speaker;
    logic                r_sounding;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic [c_HALF_W-1:0] r_half_cnt;
    logic [5:0]          r_ring_cnt;
    logic [5:0]          r_alm_hour;
    logic [6:0]          r_alm_min;

    logic                w_time_ok;
    logic                w_alarm_hit;
    logic                w_chime_lo;
    logic                w_chime_hi;
    logic [c_HALF_W-1:0] w_half_last;
    logic                w_half_wrap;
    logic                w_win_end;
    logic [5:0]          w_alm_hour_next;
    logic [6:0]          w_alm_min_next;

    // Malformed BCD time must never fire the alarm or a chime
    assign w_time_ok = (((hour[5:4] < 2'd2) && (hour[3:0] <= 4'd9)) ||
                        ((hour[5:4] == 2'd2) && (hour[3:0] <= 4'd3))) &&
                       (minute[6:4] <= 3'd5) && (minute[3:0] <= 4'd9) &&
                       (second[6:4] <= 3'd5) && (second[3:0] <= 4'd9);

    assign w_alarm_hit = tick_1hz && alm_en && !alm_set_en && w_time_ok &&
                         (hour == r_alm_hour) && (minute == r_alm_min) &&
                         (second == 7'h00);

    assign w_chime_lo = tick_1hz && w_time_ok && (minute == 7'h59) &&
                        ((second == 7'h51) || (second == 7'h53) ||
                         (second == 7'h55) || (second == 7'h57));

    assign w_chime_hi = tick_1hz && w_time_ok && (minute == 7'h59) &&
                        (second == 7'h59);

    // Only the high chime uses the short half-period; the alarm shares the low tone
    assign w_half_last = (r_state == ST_CHIME_HI) ? c_HI_LAST : c_LO_LAST;
    assign w_half_wrap = (r_half_cnt == w_half_last);
    assign w_win_end   = (r_win_cnt == c_WIN_LAST);

    // BCD increment of the alarm time with hour 23->00 and minute 59->00 wrap
    always_comb begin
        w_alm_hour_next = r_alm_hour;
        w_alm_min_next  = r_alm_min;
        if (r_alm_hour == 6'h23) begin
            w_alm_hour_next = 6'h00;
        end else if (r_alm_hour[3:0] == 4'd9) begin
            w_alm_hour_next = {r_alm_hour[5:4] + 2'd1, 4'd0};
        end else begin
            w_alm_hour_next = {r_alm_hour[5:4], r_alm_hour[3:0] + 4'd1};
        end
        if (r_alm_min == 7'h59) begin
            w_alm_min_next = 7'h00;
        end else if (r_alm_min[3:0] == 4'd9) begin
            w_alm_min_next = {r_alm_min[6:4] + 3'd1, 4'd0};
        end else begin
            w_alm_min_next = {r_alm_min[6:4], r_alm_min[3:0] + 4'd1};
        end
    end

    // Alarm time registers, adjustable only in set mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alm_hour <= 6'h00;
            r_alm_min  <= 7'h00;
        end else if (alm_set_en) begin
            if (alm_hour_inc) begin
                r_alm_hour <= w_alm_hour_next;
            end
            if (alm_min_inc) begin
                r_alm_min <= w_alm_min_next;
            end
        end
    end

    // Sequencer: state, ring counter and tone generator advance together so that
    // every sound-on interval starts from a known phase with the speaker low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_speaker  <= 1'b0;
            r_sounding <= 1'b0;
            r_win_cnt  <= '0;
            r_half_cnt <= '0;
            r_ring_cnt <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_CHIME_LO, ST_CHIME_HI: begin
                    if (tick_1hz) begin
                        // A tick re-arbitrates from scratch; alarm beats chime
                        r_win_cnt  <= '0;
                        r_half_cnt <= '0;
                        r_speaker  <= 1'b0;
                        if (w_alarm_hit && !alm_stop) begin
                            r_state    <= ST_ALARM;
                            r_ring_cnt <= 6'd0;
                            r_sounding <= 1'b1;
                        end else if (w_alarm_hit) begin
                            r_state    <= ST_IDLE;
                            r_sounding <= 1'b0;
                        end else if (w_chime_lo) begin
                            r_state    <= ST_CHIME_LO;
                            r_sounding <= 1'b1;
                        end else if (w_chime_hi) begin
                            r_state    <= ST_CHIME_HI;
                            r_sounding <= 1'b1;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_sounding <= 1'b0;
                        end
                    end else if (r_state != ST_IDLE) begin
                        if (w_win_end) begin
                            r_state    <= ST_IDLE;
                            r_sounding <= 1'b0;
                            r_speaker  <= 1'b0;
                        end else begin
                            r_win_cnt  <= r_win_cnt + 1'b1;
                            r_half_cnt <= w_half_wrap ? '0 : r_half_cnt + 1'b1;
                            if (w_half_wrap) begin
                                r_speaker <= ~r_speaker;
                            end
                        end
                    end
                end
                ST_ALARM: begin
                    if (alm_stop || !alm_en) begin
                        r_state    <= ST_IDLE;
                        r_sounding <= 1'b0;
                        r_speaker  <= 1'b0;
                    end else if (tick_1hz) begin
                        r_win_cnt  <= '0;
                        r_half_cnt <= '0;
                        r_speaker  <= 1'b0;
                        if (r_ring_cnt == c_RING_LAST) begin
                            r_state    <= ST_IDLE;
                            r_sounding <= 1'b0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + 6'd1;
                            r_sounding <= 1'b1;
                        end
                    end else if (r_sounding) begin
                        // Second is gated: sound for the first half, silent after
                        if (w_win_end) begin
                            r_sounding <= 1'b0;
                            r_speaker  <= 1'b0;
                        end else begin
                            r_win_cnt  <= r_win_cnt + 1'b1;
                            r_half_cnt <= w_half_wrap ? '0 : r_half_cnt + 1'b1;
                            if (w_half_wrap) begin
                                r_speaker <= ~r_speaker;
                            end
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_sounding <= 1'b0;
                    r_speaker  <= 1'b0;
                end
            endcase
        end
    end

    assign speaker  = r_speaker;
    assign alm_hour = r_alm_hour;
    assign alm_min  = r_alm_min;
    assign ringing  = (r_state == ST_ALARM);
    assign chiming  = (r_state == ST_CHIME_LO) || (r_state == ST_CHIME_HI);

endmodule
`default_nettype wire

// File: tb/tb_chime_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chime_alarm_ctrl
//  Description : Directed self-checking bench for chime_alarm_ctrl with a
//                per-cycle expectation queue for {speaker, chiming, ringing}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chime_alarm_ctrl;

    localparam int c_CPS = 16;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic [5:0] hour;
    logic [6:0] minute;
    logic [6:0] second;
    logic       alm_en;
    logic       alm_set_en;
    logic       alm_hour_inc;
    logic       alm_min_inc;
    logic       alm_stop;
    logic       speaker;
    logic [5:0] alm_hour;
    logic [6:0] alm_min;
    logic       ringing;
    logic       chiming;

    typedef struct {
        string      tag;
        logic [2:0] val;   // {speaker, chiming, ringing}
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    chime_alarm_ctrl #(
        .CYC_PER_SEC (c_CPS),
        .HI_HALF     (1),
        .LO_HALF     (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .hour         (hour),
        .minute       (minute),
        .second       (second),
        .alm_en       (alm_en),
        .alm_set_en   (alm_set_en),
        .alm_hour_inc (alm_hour_inc),
        .alm_min_inc  (alm_min_inc),
        .alm_stop     (alm_stop),
        .speaker      (speaker),
        .alm_hour     (alm_hour),
        .alm_min      (alm_min),
        .ringing      (ringing),
        .chiming      (chiming)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic spk, input logic chm, input logic rng);
        exp_t e;
        e.tag = tag;
        e.val = {spk, chm, rng};
        exp_q.push_back(e);
    endtask

    // Chime: half a second of tone from the entry cycle, then one silent IDLE cycle
    task automatic push_chime(input string tag, input int half, input int n);
        for (int k = 0; k < n; k++) begin
            if (k < c_CPS / 2) push(tag, 1'((k / half) % 2), 1'b1, 1'b0);
            else               push(tag, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One alarm second: low tone in the first half, silence in the second half
    task automatic push_ring(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            push(tag, (k < c_CPS / 2) ? 1'((k / 2) % 2) : 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic push_idle(input string tag, input int n);
        for (int k = 0; k < n; k++) push(tag, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock; sample 1 time unit after the edge and score one expectation
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, {13'b0, speaker, chiming, ringing}, {13'b0, e.val});
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) cycle();
        check({tag, "_drain"}, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic do_tick(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
        hour     = h;
        minute   = m;
        second   = s;
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
    endtask

    task automatic pulse(input logic hinc, input logic minc);
        alm_hour_inc = hinc;
        alm_min_inc  = minc;
        cycle();
        alm_hour_inc = 1'b0;
        alm_min_inc  = 1'b0;
    endtask

    function automatic logic [6:0] to_bcd(input int v);
        return 7'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        rst_n        = 1'b0;
        tick_1hz     = 1'b0;
        hour         = 6'h00;
        minute       = 7'h00;
        second       = 7'h00;
        alm_en       = 1'b0;
        alm_set_en   = 1'b0;
        alm_hour_inc = 1'b0;
        alm_min_inc  = 1'b0;
        alm_stop     = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(1);
        check("reset_outputs", {13'b0, speaker, chiming, ringing}, 16'h0000);
        check("reset_alm", {3'b0, alm_hour, alm_min}, 16'h0000);

        // Low chime and the even seconds around it
        push_chime("chime_lo", 2, 9);
        do_tick(6'h10, 7'h59, 7'h51);
        drain("chime_lo");
        push_idle("no_chime_52", 3); do_tick(6'h10, 7'h59, 7'h52); drain("nc52");
        push_idle("no_chime_54", 3); do_tick(6'h10, 7'h59, 7'h54); drain("nc54");
        push_idle("no_chime_56", 3); do_tick(6'h10, 7'h59, 7'h56); drain("nc56");
        push_chime("chime_lo57", 2, 9);
        do_tick(6'h10, 7'h59, 7'h57);
        drain("chime_lo57");

        // High chime, wrong minute, and a malformed hour
        push_chime("chime_hi", 1, 9);
        do_tick(6'h10, 7'h59, 7'h59);
        drain("chime_hi");
        push_idle("no_chime_58", 3); do_tick(6'h10, 7'h58, 7'h59); drain("nc58");
        push_idle("bad_bcd", 3);     do_tick(6'h2A, 7'h59, 7'h51); drain("badbcd");

        // Alarm set with wraps
        alm_set_en = 1'b1;
        for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
        check("alm_hour_23", {10'b0, alm_hour}, 16'h0023);
        pulse(1'b1, 1'b0);
        check("alm_hour_wrap", {10'b0, alm_hour}, 16'h0000);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
        check("alm_min_59", {9'b0, alm_min}, 16'h0059);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check("alm_min_61", {9'b0, alm_min}, 16'h0001);
        for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < 58; i++) pulse(1'b0, 1'b1);
        check("alm_2359", {3'b0, alm_hour, alm_min}, {3'b0, 6'h23, 7'h59});
        pulse(1'b1, 1'b1);
        check("alm_both_wrap", {3'b0, alm_hour, alm_min}, 16'h0000);
        alm_set_en = 1'b0;
        pulse(1'b1, 1'b1);
        check("alm_no_set", {3'b0, alm_hour, alm_min}, 16'h0000);
        alm_set_en = 1'b1;
        for (int i = 0; i < 7; i++)  pulse(1'b1, 1'b0);
        for (int i = 0; i < 30; i++) pulse(1'b0, 1'b1);
        alm_set_en = 1'b0;
        check("alm_0730", {3'b0, alm_hour, alm_min}, {3'b0, 6'h07, 7'h30});

        // Full ring: trigger plus 60 further ticks
        alm_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            push_ring("ring", c_CPS);
            do_tick(6'h07, 7'h30, to_bcd(i));
            run(c_CPS - 1);
        end
        push_idle("ring_end", 3);
        do_tick(6'h07, 7'h31, 7'h00);
        drain("ring_end");

        // Stop three ticks into a ring, mid-tone
        for (int i = 0; i < 3; i++) begin
            push_ring("ring_stop", c_CPS);
            do_tick(6'h07, 7'h30, to_bcd(i));
            run(c_CPS - 1);
        end
        push_ring("ring_stop", 3);
        do_tick(6'h07, 7'h30, 7'h03);
        run(2);
        push_idle("stop", 3);
        alm_stop = 1'b1;
        cycle();
        alm_stop = 1'b0;
        drain("stop");

        // Suppressions: set mode, coincident stop, disarmed
        alm_set_en = 1'b1;
        push_idle("sup_set", 3); do_tick(6'h07, 7'h30, 7'h00); drain("supset");
        alm_set_en = 1'b0;
        push_idle("sup_stop", 3);
        alm_stop = 1'b1;
        do_tick(6'h07, 7'h30, 7'h00);
        alm_stop = 1'b0;
        drain("supstop");
        alm_en = 1'b0;
        push_idle("sup_dis", 3); do_tick(6'h07, 7'h30, 7'h00); drain("supdis");

        // Disarm while ringing
        alm_en = 1'b1;
        push_ring("ring_dis", 4);
        do_tick(6'h07, 7'h30, 7'h00);
        run(3);
        push_idle("alm_en_fall", 2);
        alm_en = 1'b0;
        drain("alm_en_fall");
        alm_en = 1'b1;

        // Asynchronous reset in the middle of a high chime
        push_chime("hi_pre_rst", 1, 3);
        do_tick(6'h10, 7'h59, 7'h59);
        run(2);
        rst_n = 1'b0;
        #2;
        check("rst_async_out", {13'b0, speaker, chiming, ringing}, 16'h0000);
        check("rst_async_alm", {3'b0, alm_hour, alm_min}, 16'h0000);
        cycle();
        rst_n = 1'b1;
        push_idle("post_rst", 6);
        run(1);
        do_tick(6'h11, 7'h00, 7'h00);
        drain("post_rst");
        push_chime("post_rst_chime", 2, 9);
        do_tick(6'h11, 7'h59, 7'h53);
        drain("post_rst_chime");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chime_alarm_ctrl.md
# chime_alarm_ctrl

Speaker sequencer for the digital clock. Watches the BCD time from the time counter and drives the single speaker pin (LG1 dp / SPEAKER). It arbitrates between two sources: the hourly chime (xx:59:51/53/55/57 low tone, xx:59:59 high tone) and a user-set daily alarm. It also holds the alarm time registers, which are adjustable by pulse inputs.

## Interface
Parameters:
- CYC_PER_SEC, 1024: clk cycles per second; must be even and ≥ 8.
- HI_HALF, 1: clk cycles per half-period of the high tone.
- LO_HALF, 2: clk cycles per half-period of the low tone (also used for the alarm tone).

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse, asserted on the first clk cycle after the time counter advances
- hour  in  6  BCD hour, 00–23 ([5:4] tens, [3:0] units)
- minute  in  7  BCD minute, 00–59
- second  in  7  BCD second, 00–59
- alm_en  in  1  level; alarm armed
- alm_set_en  in  1  level; alarm-set mode (enables inc pulses, suppresses trigger)
- alm_hour_inc  in  1  one-cycle pulse; alarm hour +1
- alm_min_inc  in  1  one-cycle pulse; alarm minute +1
- alm_stop  in  1  one-cycle pulse; silences a ringing alarm
- speaker  out  1  registered tone output
- alm_hour  out  6  BCD alarm hour
- alm_min  out  7  BCD alarm minute
- ringing  out  1  high while in an ALARM state
- chiming  out  1  high while in a CHIME state

## Operation
- **Reset values:** state IDLE; speaker=0, ringing=0, chiming=0, alm_hour=00, alm_min=00; all counters cleared.
- **States:** IDLE, CHIME_LO, CHIME_HI, ALARM.
- **Time sampling:** hour, minute and second are sampled only on cycles where tick_1hz=1. Transitions decided on a tick take effect on the next cycle.
- **Alarm trigger:** on a tick with alm_en=1, alm_set_en=0, hour==alm_hour, minute==alm_min and second==00 → ALARM. The 60-tick ring counter is cleared.
- **Chime trigger:** on a tick with minute==59:
  - second ∈ {51,53,55,57} → CHIME_LO.
  - second==59 → CHIME_HI.
- **Priority:** alarm trigger beats chime trigger. A chime trigger arriving while in ALARM is ignored.
- **CHIME_LO / CHIME_HI:**
  - Tone sounds for CYC_PER_SEC/2 cycles starting on the entry cycle, then the state returns to IDLE.
  - A tick while in a CHIME state re-evaluates the triggers as if in IDLE.
- **ALARM:**
  - Each second is gated: the low tone sounds for the first CYC_PER_SEC/2 cycles after each tick (entry counts as a tick), then silence.
  - The ring counter increments on each tick. Exit to IDLE when the counter reaches 60, or on alm_stop, whichever comes first.
  - alm_stop in the same cycle as the trigger tick: stop wins, and the state stays IDLE.
  - alm_en falling while in ALARM → IDLE on the next cycle.
- **Tone generator:**
  - Half-period counter restarts on every sound-on interval start, with speaker=0 at that point.
  - speaker toggles every HI_HALF or LO_HALF cycles while sounding.
  - speaker is forced to 0 in IDLE and during gated-off intervals.
- **Alarm set (only while alm_set_en=1):**
  - alm_hour_inc: BCD +1, units 9→0 with tens +1, 23→00.
  - alm_min_inc: BCD +1, 59→00.
  - Both pulses in the same cycle: both apply.
  - Inc pulses are ignored when alm_set_en=0.
- Out-of-range BCD inputs never trigger anything.

## Timing
- Trigger tick at cycle T → state, chiming/ringing and the start of sounding all at T+1.
- First speaker rise at T+1+HALF.
- Chime sound window: cycles T+1 … T+CYC_PER_SEC/2, then IDLE.
- alm_stop at cycle S → speaker=0 and ringing=0 at S+1.
- alm_hour/alm_min update on the cycle after the inc pulse.
- Reset assertion mid-ring → all outputs take their reset values immediately (asynchronously). The alarm time is lost.

## Test plan
- **Low chime:** CYC_PER_SEC=16. Tick with 10:59:51 → chiming=1 next cycle; speaker toggles every 2 cycles for 8 cycles, then chiming=0, speaker=0. Ticks at 10:59:52/54/56 produce no sound.
- **High chime:** tick with 10:59:59 → speaker toggles every 1 cycle for 8 cycles. Tick with 10:58:59 → no chime.
- **Alarm set and wrap:** alm_set_en=1; 24 alm_hour_inc pulses → alm_hour=00. 61 alm_min_inc pulses → alm_min=01. One cycle with both pulses from 23:59 → 00:00. Pulses with alm_set_en=0 → no change.
- **Alarm ring:** alarm 07:30, alm_en=1, tick at 07:30:00 → ringing=1; sound during the first 8 cycles of each second. After 60 ticks ringing=0.
- **Stop and suppression:**
  - Repeat the ring, pulse alm_stop after 3 ticks → speaker=0 and ringing=0 next cycle.
  - Trigger tick with alm_set_en=1 → no ring.
  - alm_stop coincident with the trigger tick → no ring.
- **Reset:** assert rst_n=0 mid-CHIME_HI → speaker, chiming, alm_hour and alm_min all 0 before the next clk edge. After release, IDLE until the next trigger.
